// File: rtl/bus_8088_mem_responder.sv
// Minimum-mode 8088 bus responder: latches address on ALE, serves reads/commits writes to an internal byte array.
// Optional READY wait states are enabled with `define BUS8088_WAIT_STATE_EN.
module bus_8088_mem_responder #(
    parameter bit          IS_IO       = 1'b0,
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter int          SIZE_LOG2   = 10,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic [11:0] A,
    inout  wire  [7:0]  AD,
    input  logic        RD,
    input  logic        WR,
    input  logic        DEN,
    output logic        OE,
    output logic        READY,
    output logic        ERR
);
    localparam int CW = $clog2(WAIT_CYCLES + 1) + 1;
`ifdef BUS8088_WAIT_STATE_EN
    localparam logic [CW-1:0] WAITS = CW'(WAIT_CYCLES);
`else
    localparam logic [CW-1:0] WAITS = '0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_READ, S_WRITE} state_t;

    state_t                r_state, w_next;
    logic [7:0]            r_mem [0:(1<<SIZE_LOG2)-1];
    logic [SIZE_LOG2-1:0]  r_offset;
    logic                  r_hit;
    logic [7:0]            r_rdata, r_wdata;
    logic                  r_oe, r_err;
    logic [CW-1:0]         r_cnt, w_cnt_next, w_cnt_dec;
    logic                  w_oe_next, w_rd_load, w_capture, w_commit, w_err_set;
    logic [19:0]           w_addr;
    logic                  w_hit;

    assign w_addr    = {A, AD};
    assign w_hit     = (IOM == IS_IO) && (w_addr[19:SIZE_LOG2] == BASE_ADDR[19:SIZE_LOG2]);
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CW'(1);

    assign OE  = r_oe;
    assign ERR = r_err;
    assign AD  = (r_oe && !DEN) ? r_rdata : 8'bz;
`ifdef BUS8088_WAIT_STATE_EN
    assign READY = (r_cnt == '0);
`else
    assign READY = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        w_oe_next  = 1'b0;
        w_rd_load  = 1'b0;
        w_capture  = 1'b0;
        w_commit   = 1'b0;
        w_err_set  = 1'b0;
        if (ALE) begin
            w_next = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (!RD && !WR) begin
                        w_err_set = 1'b1;
                        w_next    = S_IDLE;
                    end else if (r_hit && !RD) begin
                        w_next     = S_READ;
                        w_rd_load  = 1'b1;
                        w_cnt_next = WAITS;
                        w_oe_next  = (WAITS == '0);
                    end else if (r_hit && !WR) begin
                        w_next     = S_WRITE;
                        w_capture  = 1'b1;
                        w_cnt_next = WAITS;
                    end
                end
                S_READ: begin
                    if (RD) begin
                        w_next = S_IDLE;
                    end else begin
                        // drive begins on the same edge the wait counter reaches zero
                        w_oe_next  = (r_cnt <= CW'(1));
                        w_cnt_next = w_cnt_dec;
                    end
                end
                S_WRITE: begin
                    if (!RD) begin
                        w_err_set = 1'b1;
                        w_next    = S_IDLE;
                    end else if (!WR) begin
                        w_capture  = 1'b1;
                        w_cnt_next = w_cnt_dec;
                    end else if (r_cnt != '0) begin
                        w_err_set = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_commit = 1'b1;
                        w_next   = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_oe     <= 1'b0;
            r_err    <= 1'b0;
            r_offset <= '0;
            r_hit    <= 1'b0;
            r_rdata  <= 8'h00;
            r_wdata  <= 8'h00;
            r_cnt    <= '0;
        end else begin
            r_oe  <= w_oe_next;
            r_cnt <= w_cnt_next;
            if (w_err_set) r_err <= 1'b1;
            if (ALE) begin
                r_offset <= w_addr[SIZE_LOG2-1:0];
                r_hit    <= w_hit;
            end
            if (w_rd_load) r_rdata <= r_mem[r_offset];
            if (w_capture) r_wdata <= AD;
        end
    end

    // Array has no reset so its contents survive RESET.
    always_ff @(posedge CLK) begin
        if (w_commit && !RESET) r_mem[r_offset] <= r_wdata;
    end
endmodule

// File: tb/tb_bus_8088_mem_responder.sv
// Bench for bus_8088_mem_responder: a memory-space and an IO-space responder driven with identical bus cycles.
module tb_bus_8088_mem_responder;
`ifdef BUS8088_WAIT_STATE_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif

    logic        CLK = 0, RESET, ALE, IOM, RD, WR, DEN;
    logic [11:0] A;
    logic [7:0]  tb_ad;
    logic        tb_ad_en;
    wire  [7:0]  AD_m, AD_i;
    logic        OE_m, RDY_m, ERR_m, OE_i, RDY_i, ERR_i;
    int          checks = 0, errors = 0;

    // reference model: one byte array per responder (0 = memory, 1 = IO)
    logic [7:0]  mm [2][1024];
    bit          mv [2][1024];

    assign AD_m = tb_ad_en ? tb_ad : 8'bz;
    assign AD_i = tb_ad_en ? tb_ad : 8'bz;

    always #5 CLK = ~CLK;

    bus_8088_mem_responder #(.IS_IO(1'b0), .BASE_ADDR(20'h00000), .SIZE_LOG2(10), .WAIT_CYCLES(2)) dut_m (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .A(A), .AD(AD_m),
        .RD(RD), .WR(WR), .DEN(DEN), .OE(OE_m), .READY(RDY_m), .ERR(ERR_m));
    bus_8088_mem_responder #(.IS_IO(1'b1), .BASE_ADDR(20'h00000), .SIZE_LOG2(10), .WAIT_CYCLES(2)) dut_i (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .A(A), .AD(AD_i),
        .RD(RD), .WR(WR), .DEN(DEN), .OE(OE_i), .READY(RDY_i), .ERR(ERR_i));

    // window is [0, 1024) in the responder's own address space
    function automatic bit is_hit(logic [19:0] a, logic iom, int k);
        return (iom == (k == 1)) && (a < 20'd1024);
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_ale(input logic [19:0] addr, input logic iom);
        ALE = 1; IOM = iom; A = addr[19:8]; tb_ad = addr[7:0]; tb_ad_en = 1;
        cyc();
        ALE = 0; tb_ad_en = 0;
    endtask

    task automatic do_write(input logic [19:0] addr, input logic iom, input logic [7:0] d, input int hold);
        do_ale(addr, iom);
        WR = 0; tb_ad = d; tb_ad_en = 1;
        repeat (hold) cyc();
        WR = 1; tb_ad_en = 0;
        cyc();
        for (int k = 0; k < 2; k++)
            if (is_hit(addr, iom, k) && hold >= WAITS + 1) begin
                mm[k][addr[9:0]] = d;
                mv[k][addr[9:0]] = 1;
            end
    endtask

    task automatic do_read(input logic [19:0] addr, input logic iom);
        bit hm, hi;
        hm = is_hit(addr, iom, 0);
        hi = is_hit(addr, iom, 1);
        do_ale(addr, iom);
        RD = 0; DEN = 0;
        for (int j = 0; j <= WAITS; j++) begin
            cyc();
            checks++;
            if (OE_m !== (hm && j == WAITS) || RDY_m !== (!hm || j == WAITS)) begin
                errors++;
                $display("FAIL rd_mem_oe_ready addr=%h iom=%b j=%0d got oe=%b ready=%b want oe=%b ready=%b",
                         addr, iom, j, OE_m, RDY_m, hm && j == WAITS, !hm || j == WAITS);
            end
            checks++;
            if (OE_i !== (hi && j == WAITS) || RDY_i !== (!hi || j == WAITS)) begin
                errors++;
                $display("FAIL rd_io_oe_ready addr=%h iom=%b j=%0d got oe=%b ready=%b want oe=%b ready=%b",
                         addr, iom, j, OE_i, RDY_i, hi && j == WAITS, !hi || j == WAITS);
            end
        end
        if (hm && mv[0][addr[9:0]]) begin
            checks++;
            if (AD_m !== mm[0][addr[9:0]]) begin
                errors++;
                $display("FAIL rd_mem_data addr=%h got %h want %h", addr, AD_m, mm[0][addr[9:0]]);
            end
        end
        if (hi && mv[1][addr[9:0]]) begin
            checks++;
            if (AD_i !== mm[1][addr[9:0]]) begin
                errors++;
                $display("FAIL rd_io_data addr=%h got %h want %h", addr, AD_i, mm[1][addr[9:0]]);
            end
        end
        RD = 1; DEN = 1;
        cyc();
        checks++;
        if (OE_m !== 1'b0 || OE_i !== 1'b0) begin
            errors++;
            $display("FAIL rd_release addr=%h got oe_m=%b oe_i=%b want 0 0", addr, OE_m, OE_i);
        end
    endtask

    task automatic test_reset();
        RESET = 1;
        repeat (2) cyc();
        checks++;
        if ({OE_m, RDY_m, ERR_m} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mem got oe/rdy/err=%b want 010", {OE_m, RDY_m, ERR_m});
        end
        checks++;
        if ({OE_i, RDY_i, ERR_i} !== 3'b010) begin
            errors++;
            $display("FAIL reset_io got oe/rdy/err=%b want 010", {OE_i, RDY_i, ERR_i});
        end
        RESET = 0;
        cyc();
    endtask

    task automatic test_write_read();
        do_write(20'h00012, 1'b0, 8'hA5, WAITS + 2);
        do_read(20'h00012, 1'b0);
    endtask

    task automatic test_miss();
        do_write(20'h00000, 1'b0, 8'h66, WAITS + 1);
        do_write(20'h00400, 1'b0, 8'h99, WAITS + 1);
        do_read(20'h00400, 1'b0);
        do_read(20'h00000, 1'b0);
    endtask

    task automatic test_io();
        do_write(20'h00012, 1'b1, 8'h3C, WAITS + 1);
        do_read(20'h00012, 1'b1);
        do_read(20'h00012, 1'b0);
    endtask

    task automatic test_random();
        logic [19:0] a;
        logic        iom;
        for (int n = 0; n < 60; n++) begin
            a   = 20'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 20'h00400 : 20'h0);
            iom = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                do_write(a, iom, 8'($urandom), WAITS + 1 + $urandom_range(0, 2));
            else
                do_read(a, iom);
        end
    endtask

    task automatic test_abort();
        do_write(20'h00005, 1'b0, 8'h11, WAITS + 1);
        do_ale(20'h00005, 1'b0);
        WR = 0; tb_ad = 8'hFF; tb_ad_en = 1;
        cyc();
        RESET = 1;
        cyc();
        checks++;
        if (OE_m !== 1'b0 || ERR_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write got oe=%b err=%b want 0 0", OE_m, ERR_m);
        end
        RESET = 0; WR = 1; tb_ad_en = 0;
        cyc();
        do_read(20'h00005, 1'b0);
        // ALE while a read is being driven
        do_ale(20'h00012, 1'b0);
        RD = 0; DEN = 0;
        repeat (WAITS + 1) cyc();
        checks++;
        if (OE_m !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_oe got %b want 1", OE_m);
        end
        DEN = 1; ALE = 1; A = 12'h000; tb_ad = 8'h40; tb_ad_en = 1;
        cyc();
        checks++;
        if (OE_m !== 1'b0) begin
            errors++;
            $display("FAIL ale_mid_read_oe got %b want 0", OE_m);
        end
        ALE = 0; RD = 1; tb_ad_en = 0;
        cyc();
    endtask

    task automatic test_proto_err();
        do_write(20'h00030, 1'b0, 8'h5A, WAITS + 1);
        do_ale(20'h00030, 1'b0);
        RD = 0; WR = 0;
        cyc();
        RD = 1; WR = 1;
        checks++;
        if (ERR_m !== 1'b1 || OE_m !== 1'b0) begin
            errors++;
            $display("FAIL proto_err_set got err=%b oe=%b want 1 0", ERR_m, OE_m);
        end
        repeat (3) cyc();
        do_read(20'h00030, 1'b0);
        checks++;
        if (ERR_m !== 1'b1) begin
            errors++;
            $display("FAIL proto_err_sticky got %b want 1", ERR_m);
        end
        RESET = 1;
        cyc();
        RESET = 0;
        checks++;
        if (ERR_m !== 1'b0 || ERR_i !== 1'b0) begin
            errors++;
            $display("FAIL proto_err_clear got err_m=%b err_i=%b want 0 0", ERR_m, ERR_i);
        end
        cyc();
    endtask

`ifdef BUS8088_WAIT_STATE_EN
    task automatic test_wait_early_wr();
        do_write(20'h00020, 1'b0, 8'h44, WAITS + 1);
        do_ale(20'h00020, 1'b0);
        WR = 0; tb_ad = 8'h77; tb_ad_en = 1;
        cyc();
        WR = 1; tb_ad_en = 0;
        cyc();
        checks++;
        if (ERR_m !== 1'b1) begin
            errors++;
            $display("FAIL wait_early_wr_err got %b want 1", ERR_m);
        end
        do_read(20'h00020, 1'b0);
        RESET = 1;
        cyc();
        RESET = 0;
        cyc();
    endtask
`endif

    initial begin
        RESET = 1; ALE = 0; IOM = 0; A = '0; RD = 1; WR = 1; DEN = 1;
        tb_ad = '0; tb_ad_en = 0;
        test_reset();
        test_write_read();
        test_miss();
        test_io();
        test_abort();
        test_proto_err();
`ifdef BUS8088_WAIT_STATE_EN
        test_wait_early_wr();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
